// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for the RV32I datapath: decodes the IR fields once in
// DECODE, then drives every datapath strobe as a function of state and registered class.
module multicycle_control_unit #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic                     ula_zero,
    input  logic                     ula_lt,
    input  logic                     ula_ltu,
    input  logic                     mem_ready,
    output logic                     load_ir,
    output logic                     load_pc,
    output logic                     WE_RF,
    output logic                     WE_MEM,
    output logic                     ULA_din2_sel,
    output logic [1:0]               RF_din_sel,
    output logic                     pc_next_sel,
    output logic                     pc_adder_sel,
    output logic [3:0]               ULA_op,
    output logic                     illegal_instr,
    output logic [2:0]               state,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [2:0] C_R      = 3'd0;
    localparam logic [2:0] C_IALU   = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_AUIPC  = 3'd5;
    localparam logic [2:0] C_JAL    = 3'd6;
    localparam logic [2:0] C_JALR   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [2:0]               state_q, state_d;
    logic [2:0]               class_q, class_d;
    logic [2:0]               funct3_q, funct3_d;
    logic                     funct7_5_q, funct7_5_d;
    logic                     illegal_q, illegal_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic [2:0] decClass;
    logic       decValid;
    logic [3:0] heldUlaOp;
    logic       branchTaken;
    logic       retire;
    logic       loadIrRaw, loadPcRaw, weRfRaw, weMemRaw;

    always_comb begin
        decClass = C_R;
        decValid = 1'b1;
        case (opcode)
            OP_R:      decClass = C_R;
            OP_IALU:   decClass = C_IALU;
            OP_LOAD:   decClass = C_LOAD;
            OP_STORE:  decClass = C_STORE;
            OP_BRANCH: begin
                decClass = C_BRANCH;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    decValid = 1'b0;
                end
            end
            OP_AUIPC:  decClass = C_AUIPC;
            OP_JAL:    decClass = C_JAL;
            OP_JALR:   decClass = C_JALR;
            default:   decValid = 1'b0;
        endcase
    end

    // Only shifts (funct3=101) use the alternate bit among immediate ALU ops.
    always_comb begin
        heldUlaOp = 4'b0000;
        case (class_q)
            C_R:      heldUlaOp = {funct7_5_q, funct3_q};
            C_IALU:   heldUlaOp = {(funct3_q == 3'b101) ? funct7_5_q : 1'b0, funct3_q};
            C_BRANCH: heldUlaOp = 4'b1000;
            default:  heldUlaOp = 4'b0000;
        endcase
    end

    always_comb begin
        branchTaken = 1'b0;
        case (funct3_q)
            3'b000:  branchTaken = ula_zero;
            3'b001:  branchTaken = ~ula_zero;
            3'b100:  branchTaken = ula_lt;
            3'b101:  branchTaken = ~ula_lt;
            3'b110:  branchTaken = ula_ltu;
            3'b111:  branchTaken = ~ula_ltu;
            default: branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        funct3_d     = funct3_q;
        funct7_5_d   = funct7_5_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        loadIrRaw    = 1'b0;
        loadPcRaw    = 1'b0;
        weRfRaw      = 1'b0;
        weMemRaw     = 1'b0;
        ULA_din2_sel = 1'b0;
        RF_din_sel   = 2'd0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        ULA_op       = 4'b0000;

        case (state_q)
            S_FETCH: begin
                loadIrRaw = 1'b1;
                state_d   = S_DECODE;
            end

            S_DECODE: begin
                funct3_d   = funct3;
                funct7_5_d = funct7_5;
                if (decValid) begin
                    class_d = decClass;
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end

            S_EXEC: begin
                ULA_din2_sel = (class_q != C_R) && (class_q != C_BRANCH);
                ULA_op       = heldUlaOp;
                if (class_q == C_BRANCH) begin
                    loadPcRaw    = 1'b1;
                    pc_adder_sel = 1'b1;
                    pc_next_sel  = branchTaken;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if (class_q == C_LOAD || class_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            // Stores retire straight out of MEM; loads still need a write-back cycle.
            S_MEM: begin
                ULA_din2_sel = 1'b1;
                ULA_op       = 4'b0000;
                if (class_q == C_STORE) begin
                    weMemRaw = 1'b1;
                    if (mem_ready) begin
                        loadPcRaw = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                end else if (mem_ready) begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                weRfRaw   = 1'b1;
                loadPcRaw = 1'b1;
                retire    = 1'b1;
                ULA_op    = heldUlaOp;
                state_d   = S_FETCH;
                case (class_q)
                    C_LOAD:  RF_din_sel = 2'd0;
                    C_AUIPC: begin
                        RF_din_sel   = 2'd3;
                        pc_adder_sel = 1'b1;
                    end
                    C_JAL: begin
                        RF_din_sel   = 2'd2;
                        pc_adder_sel = 1'b1;
                        pc_next_sel  = 1'b1;
                    end
                    C_JALR: begin
                        RF_din_sel  = 2'd2;
                        pc_next_sel = 1'b1;
                    end
                    default: RF_din_sel = 2'd1;
                endcase
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset is synchronous, so strobes are masked combinationally to abort mid-instruction at once.
    assign load_ir = loadIrRaw & ~reset;
    assign load_pc = loadPcRaw & ~reset;
    assign WE_RF   = weRfRaw & ~reset;
    assign WE_MEM  = weMemRaw & ~reset;

    assign instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, retire};

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_FETCH;
            class_q    <= C_R;
            funct3_q   <= 3'b000;
            funct7_5_q <= 1'b0;
            illegal_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            funct3_q   <= funct3_d;
            funct7_5_q <= funct7_5_d;
            illegal_q  <= illegal_d;
            instret_q  <= instret_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign state         = state_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level model scripts the
// expected per-cycle control vector, and one negedge process compares it to the DUT.
module tb_multicycle_control_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        ula_zero, ula_lt, ula_ltu, mem_ready;
    logic        load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel;
    logic [1:0]  RF_din_sel;
    logic        pc_next_sel, pc_adder_sel;
    logic [3:0]  ULA_op;
    logic        illegal_instr;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.INSTRET_WIDTH(32)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .ula_zero(ula_zero), .ula_lt(ula_lt), .ula_ltu(ula_ltu), .mem_ready(mem_ready),
        .load_ir(load_ir), .load_pc(load_pc), .WE_RF(WE_RF), .WE_MEM(WE_MEM),
        .ULA_din2_sel(ULA_din2_sel), .RF_din_sel(RF_din_sel), .pc_next_sel(pc_next_sel),
        .pc_adder_sel(pc_adder_sel), .ULA_op(ULA_op), .illegal_instr(illegal_instr),
        .state(state), .instret(instret)
    );

    typedef struct packed {
        logic       loadIr;
        logic       loadPc;
        logic       weRf;
        logic       weMem;
        logic       din2;
        logic [1:0] rfSel;
        logic       pcNext;
        logic       pcAdd;
        logic [3:0] ulaOp;
        logic       illegal;
        logic [2:0] st;
    } vec_t;

    typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_AUIPC, K_JAL, K_JALR, K_BAD} kind_t;

    vec_t        expVec, actVec;
    logic        expValid = 1'b0;
    logic [31:0] expInstret;
    logic        modelIllegal;
    string       stepName = "none";
    int          checks = 0;
    int          failures = 0;
    int          cyc;

    function automatic kind_t kindOf(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? K_BAD : K_BR;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] aluOp(input kind_t k, input logic [2:0] f3, input logic f7);
        if (k == K_R) return {f7, f3};
        if (k == K_I) return (f3 == 3'b101) ? {f7, f3} : {1'b0, f3};
        if (k == K_BR) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic takenOf(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            default: return !ltu;
        endcase
    endfunction

    function automatic vec_t base(input logic [2:0] st);
        vec_t v;
        v = '0;
        v.st = st;
        v.illegal = modelIllegal;
        return v;
    endfunction

    // Every cycle with a scripted expectation is compared away from the active edge.
    always @(negedge CLK) begin
        if (expValid) begin
            actVec = {load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel, RF_din_sel, pc_next_sel,
                      pc_adder_sel, ULA_op, illegal_instr, state};
            checks++;
            if (actVec !== expVec) begin
                failures++;
                $display("[TB] FAIL %s ctrl actual=%h required=%h", stepName, actVec, expVec);
            end
            checks++;
            if (instret !== expInstret) begin
                failures++;
                $display("[TB] FAIL %s instret actual=%0d required=%0d", stepName, instret, expInstret);
            end
        end
    end

    task automatic step(input vec_t v, input string nm, input logic retires);
        expVec = v;
        stepName = nm;
        expValid = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        if (retires) expInstret++;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Runs one instruction from FETCH; abortAt >= 0 asserts reset in that MEM cycle.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic lt, input logic ltu,
                                 input int waits, input int abortAt, output int cycles);
        kind_t k;
        vec_t  v;
        k = kindOf(op, f3);
        opcode = op; funct3 = f3; funct7_5 = f7;
        ula_zero = z; ula_lt = lt; ula_ltu = ltu; mem_ready = 1'b0;
        cycles = 0;
        v = base(3'd0); v.loadIr = 1'b1;
        step(v, "fetch", 1'b0); cycles++;
        v = base(3'd1);
        step(v, "decode", 1'b0); cycles++;
        if (k == K_BAD) begin
            modelIllegal = 1'b1;
            return;
        end
        v = base(3'd2);
        v.din2 = (k != K_R) && (k != K_BR);
        v.ulaOp = aluOp(k, f3, f7);
        if (k == K_BR) begin
            v.loadPc = 1'b1; v.pcAdd = 1'b1; v.pcNext = takenOf(f3, z, lt, ltu);
            step(v, "exec", 1'b1); cycles++;
            return;
        end
        step(v, "exec", 1'b0); cycles++;
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= waits; i++) begin
                mem_ready = (i == waits);
                v = base(3'd3); v.din2 = 1'b1;
                if (i == abortAt) begin
                    reset = 1'b1;
                    step(v, "memAbort", 1'b0); cycles++;
                    reset = 1'b0; mem_ready = 1'b0;
                    expInstret = 0; modelIllegal = 1'b0;
                    return;
                end
                if (k == K_STORE) begin
                    v.weMem = 1'b1;
                    v.loadPc = (i == waits);
                end
                step(v, "mem", (k == K_STORE) && (i == waits)); cycles++;
            end
            mem_ready = 1'b0;
            if (k == K_STORE) return;
        end
        v = base(3'd4); v.weRf = 1'b1; v.loadPc = 1'b1; v.ulaOp = aluOp(k, f3, f7);
        case (k)
            K_LOAD:  v.rfSel = 2'd0;
            K_AUIPC: begin v.rfSel = 2'd3; v.pcAdd = 1'b1; end
            K_JAL:   begin v.rfSel = 2'd2; v.pcAdd = 1'b1; v.pcNext = 1'b1; end
            K_JALR:  begin v.rfSel = 2'd2; v.pcNext = 1'b1; end
            default: v.rfSel = 2'd1;
        endcase
        step(v, "wb", 1'b1); cycles++;
    endtask

    task automatic trapCycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = i[0];
            ula_zero = i[1];
            step(base(3'd7), "trap", 1'b0);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        ula_zero = 1'b0; ula_lt = 1'b0; ula_ltu = 1'b0; mem_ready = 1'b0;
        modelIllegal = 1'b0; expInstret = 0;

        checkOutput("modelSubOp", 32'(aluOp(K_R, 3'b000, 1'b1)), 32'h8);
        checkOutput("modelSraiOp", 32'(aluOp(K_I, 3'b101, 1'b1)), 32'hD);
        checkOutput("modelAddiAlt", 32'(aluOp(K_I, 3'b000, 1'b1)), 32'h0);
        checkOutput("modelBgeLt", 32'(takenOf(3'b101, 1'b0, 1'b1, 1'b0)), 32'h0);

        @(posedge CLK); #1;
        step(base(3'd0), "reset", 1'b0);
        reset = 1'b0;
        checkOutput("resetState", 32'(state), 32'h0);

        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        checkOutput("addLatency", cyc, 4);
        checkOutput("addInstret", instret, 1);
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        checkOutput("sraiInstret", instret, 3);
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);

        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, -1, cyc);
        checkOutput("loadLatency", cyc, 8);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        checkOutput("storeLatency", cyc, 4);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1, cyc);

        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, cyc);
        checkOutput("beqLatency", cyc, 3);
        applyStimulus(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);

        applyStimulus(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        checkOutput("jalrInstret", instret, 17);

        applyStimulus(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        trapCycles(10);
        checkOutput("trapState", 32'(state), 32'h7);
        checkOutput("trapIllegal", 32'(illegal_instr), 32'h1);

        reset = 1'b1;
        step(base(3'd7), "trapReset", 1'b0);
        reset = 1'b0; modelIllegal = 1'b0; expInstret = 0;
        checkOutput("postResetIllegal", 32'(illegal_instr), 32'h0);

        applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2, cyc);
        checkOutput("abortState", 32'(state), 32'h0);
        checkOutput("abortInstret", instret, 0);
        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);

        applyStimulus(7'b1100011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, cyc);
        trapCycles(2);
        checkOutput("branchTrapIllegal", 32'(illegal_instr), 32'h1);

        expValid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
